// File: rtl/frame_serializer.sv
// frame_serializer
//   Transmit side of the 11-bit serial frame link. One byte is taken per
//   valid_in/ready_out handshake and sent as start bit, data bits LSB first,
//   parity bit and stop bit. Each bit lasts CLKS_PER_BIT clocks. The line then
//   idles high for GAP_BITS bit-times before the next byte is accepted.
//
// Ports
//   clk        in   1  clock, all logic on posedge
//   reset      in   1  synchronous, active-high reset
//   data_in    in   8  byte to send, sampled only on accept
//   valid_in   in   1  data_in valid
//   ready_out  out  1  block can accept (accept = valid_in & ready_out)
//   tx         out  1  serial line, idles high
//   bit_tick   out  1  one-cycle pulse at the centre of each transmitted bit
//   busy       out  1  high from the cycle after accept until ready_out returns
//   done       out  1  one-cycle pulse in the first cycle after the stop bit
module frame_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int GAP_BITS     = 1,
    parameter bit PARITY_ODD   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       bit_tick,
    output logic       busy,
    output logic       done
);

    localparam int CYC_W    = $clog2(CLKS_PER_BIT);
    localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
    localparam int GAP_W    = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CLKS_PER_BIT - 1);
    localparam logic [CYC_W-1:0] CYC_MID  = CYC_W'(CLKS_PER_BIT / 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_e;

    state_e            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [3:0]        bit_q, bit_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [10:0]       frame_q, frame_d;
    logic              tx_q, tx_d;
    logic              tick_q, tick_d;
    logic              fin_q, fin_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              frame_end;
    logic              gap_end;
    logic              parity;

    assign accept    = valid_in & ready_q;
    assign frame_end = (state_q == SEND) && (cyc_q == CYC_LAST) && (bit_q == 4'd10);
    assign gap_end   = (state_q == GAP) && (gap_q == GAP_LAST);
    assign parity    = PARITY_ODD ? ~^data_in : ^data_in;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = SEND;
            SEND: begin
                if (frame_end) begin
                    if (GAP_CLKS == 0) state_d = IDLE;
                    else               state_d = GAP;
                end
            end
            GAP:  if (gap_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values.
    // tx and bit_tick are registered from cyc/bit, so the line trails the
    // counters by one clock; that lag is the one-cycle start latency after
    // accept. fin_q marks the cycle after the last stop-bit count so done
    // lands in the first cycle after the stop bit has left the line.
    always_comb begin
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        frame_d = frame_q;
        tx_d    = 1'b1;
        tick_d  = 1'b0;
        fin_d   = frame_end;
        done_d  = fin_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    frame_d = {1'b0, data_in[0], data_in[1], data_in[2], data_in[3],
                               data_in[4], data_in[5], data_in[6], data_in[7],
                               parity, 1'b1};
                    cyc_d   = '0;
                    bit_d   = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SEND: begin
                tx_d   = frame_q[10];
                tick_d = (cyc_q == CYC_MID);
                gap_d  = '0;
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    bit_d   = bit_q + 4'd1;
                    frame_d = {frame_q[9:0], 1'b1};
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            GAP: begin
                gap_d = gap_q + GAP_W'(1);
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
        // Without a gap, ready returns together with done.
        if (gap_end || ((GAP_CLKS == 0) && fin_q)) begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            frame_q <= '1;
            tx_q    <= 1'b1;
            tick_q  <= 1'b0;
            fin_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
            tick_q  <= tick_d;
            fin_q   <= fin_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign ready_out = ready_q;
    assign tx        = tx_q;
    assign bit_tick  = tick_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer
//   Scoreboard bench for frame_serializer. Two instances: A (4 clocks/bit,
//   1 gap bit) and B (2 clocks/bit, no gap). Drivers push hand-computed
//   receiver words and accept times; per-instance monitors run a model
//   receiver that shifts tx on bit_tick and compare on every done pulse.
module tb_frame_serializer;

    localparam int CA = 4;
    localparam int GA = 1;
    localparam int CB = 2;
    localparam int GB = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din_a, din_b;
    logic       vld_a, vld_b;
    logic       rdy_a, tx_a, tick_a, busy_a, done_a;
    logic       rdy_b, tx_b, tick_b, busy_b, done_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cnt      = 0;

    logic [10:0] exp_a[$];
    logic [10:0] exp_b[$];
    int unsigned acc_a[$];
    int unsigned acc_b[$];
    int unsigned last_done_a = 0;
    int unsigned last_done_b = 0;

    frame_serializer #(.CLKS_PER_BIT(CA), .GAP_BITS(GA), .PARITY_ODD(1'b1)) dut_a (
        .clk(clk), .reset(rst), .data_in(din_a), .valid_in(vld_a),
        .ready_out(rdy_a), .tx(tx_a), .bit_tick(tick_a), .busy(busy_a), .done(done_a)
    );

    frame_serializer #(.CLKS_PER_BIT(CB), .GAP_BITS(GB), .PARITY_ODD(1'b1)) dut_b (
        .clk(clk), .reset(rst), .data_in(din_b), .valid_in(vld_b),
        .ready_out(rdy_b), .tx(tx_b), .bit_tick(tick_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor A
    logic [10:0] sh_a;
    int unsigned nt_a;
    logic [10:0] e_a;
    int unsigned k_a;
    initial begin
        sh_a = '0;
        nt_a = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_a.delete();
                acc_a.delete();
                nt_a = 0;
            end else begin
                if (tick_a) begin
                    if (acc_a.size() == 0) fail("tick_a outside frame");
                    else check("tick_a time", cnt, acc_a[0] + 1 + nt_a * CA + CA / 2);
                    sh_a = {sh_a[9:0], tx_a};
                    nt_a++;
                end
                if (done_a) begin
                    if (exp_a.size() == 0) begin
                        fail("done_a without pending frame");
                    end else begin
                        e_a = exp_a.pop_front();
                        k_a = acc_a.pop_front();
                        check("rx_a word", sh_a, e_a);
                        check("done_a latency", cnt - k_a, 1 + 11 * CA);
                        check("ticks_a per frame", nt_a, 11);
                    end
                    nt_a = 0;
                    last_done_a = cnt;
                end
                if (!busy_a) check("tx_a high when not busy", tx_a, 1'b1);
            end
        end
    end

    // Monitor B
    logic [10:0] sh_b;
    int unsigned nt_b;
    logic [10:0] e_b;
    int unsigned k_b;
    initial begin
        sh_b = '0;
        nt_b = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_b.delete();
                acc_b.delete();
                nt_b = 0;
            end else begin
                if (tick_b) begin
                    if (acc_b.size() == 0) fail("tick_b outside frame");
                    else check("tick_b time", cnt, acc_b[0] + 1 + nt_b * CB + CB / 2);
                    sh_b = {sh_b[9:0], tx_b};
                    nt_b++;
                end
                if (done_b) begin
                    if (exp_b.size() == 0) begin
                        fail("done_b without pending frame");
                    end else begin
                        e_b = exp_b.pop_front();
                        k_b = acc_b.pop_front();
                        check("rx_b word", sh_b, e_b);
                        check("done_b latency", cnt - k_b, 1 + 11 * CB);
                        check("ticks_b per frame", nt_b, 11);
                    end
                    nt_b = 0;
                    last_done_b = cnt;
                end
            end
        end
    end

    // Called at a negedge. Returns at the negedge after the accept edge k.
    task automatic send(input int which, input logic [7:0] d, input logic [10:0] w,
                        input bit keep_valid, output int unsigned k);
        int unsigned waited;
        waited = 0;
        k = 0;
        if (which == 0) begin din_a = d; vld_a = 1'b1; end
        else            begin din_b = d; vld_b = 1'b1; end
        while (((which == 0) ? rdy_a : rdy_b) !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 400) begin
            fail("accept timeout");
            vld_a = 1'b0;
            vld_b = 1'b0;
        end else begin
            k = cnt + 1;
            if (which == 0) begin exp_a.push_back(w); acc_a.push_back(k); end
            else            begin exp_b.push_back(w); acc_b.push_back(k); end
            @(negedge clk);
            if (!keep_valid) begin
                // Changing data after accept must not disturb the frame.
                if (which == 0) begin vld_a = 1'b0; din_a = ~d; end
                else            begin vld_b = 1'b0; din_b = ~d; end
            end
        end
    endtask

    task automatic wait_done(input int which, output int unsigned t);
        int unsigned w;
        w = 0;
        while (((which == 0) ? done_a : done_b) !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) fail("done timeout");
        t = cnt;
        @(negedge clk);
    endtask

    task automatic wait_ready(input int which, output int unsigned t);
        int unsigned w;
        w = 0;
        while (((which == 0) ? rdy_a : rdy_b) !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) fail("ready timeout");
        t = cnt;
    endtask

    int unsigned k1, k2, td, tr;

    initial begin
        rst = 1'b1;
        vld_a = 1'b0; vld_b = 1'b0;
        din_a = '0;   din_b = '0;
        repeat (3) @(negedge clk);
        check("reset tx", tx_a, 1'b1);
        check("reset ready_out", rdy_a, 1'b1);
        check("reset busy", busy_a, 1'b0);
        check("reset bit_tick", tick_a, 1'b0);
        check("reset done", done_a, 1'b0);
        check("reset tx_b", tx_b, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // 1: 0xA5 -> bits 0,1,0,1,0,0,1,0,1,1,1
        send(0, 8'hA5, 11'h297, 1'b0, k1);
        check("busy after accept", busy_a, 1'b1);
        check("ready low after accept", rdy_a, 1'b0);
        wait_done(0, td);
        check("t1 done latency", td - k1, 45);
        wait_ready(0, tr);
        check("t1 ready after done", tr - td, 4);
        check("t1 busy with ready", busy_a, 1'b0);

        // 2: corner data patterns, parity 1, 1, 0
        send(0, 8'h00, 11'h003, 1'b0, k1); wait_done(0, td);
        send(0, 8'hFF, 11'h3FF, 1'b0, k1); wait_done(0, td);
        send(0, 8'h01, 11'h201, 1'b0, k1); wait_done(0, td);

        // 3: valid held high across two frames. The tx-high run between them is
        //    the gap plus the done/ready cycle and the accept cycle.
        send(0, 8'h3C, 11'h0F3, 1'b1, k1);
        send(0, 8'hC3, 11'h30F, 1'b0, k2);
        check("t3 idle clocks between frames", k2 + 1 - last_done_a, GA * CA + 2);
        wait_done(0, td);
        check("t3 scoreboard drained", exp_a.size(), 0);

        // 4: reset at bit 5, with valid_in high during reset
        wait_ready(0, tr);
        send(0, 8'h77, 11'h000, 1'b0, k1);
        repeat (22) @(negedge clk);
        rst = 1'b1; vld_a = 1'b1; din_a = 8'h12;
        @(negedge clk);
        check("t4 tx after reset", tx_a, 1'b1);
        check("t4 ready after reset", rdy_a, 1'b1);
        check("t4 done after reset", done_a, 1'b0);
        @(negedge clk);
        check("t4 reset beats valid", busy_a, 1'b0);
        rst = 1'b0; vld_a = 1'b0;
        repeat (60) @(negedge clk);
        check("t4 no resumed frame", busy_a, 1'b0);
        // 0x5A LSB first: 0 0101 1010 then parity 1, stop 1
        send(0, 8'h5A, 11'h16B, 1'b0, k1);
        wait_done(0, td);

        // 5: valid pulse while busy is ignored
        wait_ready(0, tr);
        send(0, 8'h0F, 11'h3C3, 1'b0, k1);
        repeat (10) @(negedge clk);
        vld_a = 1'b1; din_a = 8'hEE;
        @(negedge clk);
        vld_a = 1'b0;
        wait_done(0, td);
        wait_ready(0, tr);
        repeat (20) @(negedge clk);
        check("t5 no second frame", busy_a, 1'b0);
        check("t5 tx idle", tx_a, 1'b1);
        check("t5 scoreboard drained", exp_a.size(), 0);

        // 6: instance B, 2 clocks/bit, no gap, back-to-back
        send(1, 8'hA5, 11'h297, 1'b1, k1);
        send(1, 8'h3C, 11'h0F3, 1'b0, k2);
        check("t6 idle clocks between frames", k2 + 1 - last_done_b, GB * CB + 2);
        wait_done(1, td);
        repeat (4) @(negedge clk);
        check("t6 scoreboard drained", exp_b.size(), 0);
        check("t6 busy_b idle", busy_b, 1'b0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
